// File: rtl/lfsr_draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_draw_pkg
// Purpose  : Shared FSM state type and round-robin pick helper for the
//            LFSR draw arbiter.
// Revision : 1.0
// ============================================================================
package lfsr_draw_pkg;

    localparam int c_MAX_REQ = 32;
    localparam int c_MAX_IDX_W = $clog2(c_MAX_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // First set request at or after ptr, wrapping; returns ptr when none is set.
    function automatic int next_rr(input int ptr, input logic [c_MAX_REQ-1:0] req,
                                   input int num_req);
        int idx;
        next_rr = ptr;
        for (int k = c_MAX_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                idx = ptr + k;
                if (idx >= num_req) idx = idx - num_req;
                if (req[idx[c_MAX_IDX_W-1:0]]) next_rr = idx;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_draw_arbiter_if
// Purpose  : Request/response bundle between requesters and the draw arbiter.
// Revision : 1.0
// ============================================================================
interface lfsr_draw_arbiter_if #(
    parameter int WIDTH   = 7,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] bound;
    logic                     reseed;
    logic [WIDTH-1:0]         seed_in;
    logic [NUM_REQ-1:0]       grant;
    logic                     valid;
    logic [WIDTH-1:0]         data;
    logic                     timed_out;
    logic                     busy;

    modport master (
        output req, bound, reseed, seed_in,
        input  grant, valid, data, timed_out, busy
    );

    modport slave (
        input  req, bound, reseed, seed_in,
        output grant, valid, data, timed_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core
// Purpose  : Fibonacci LFSR with loadable state and all-zero lock-up guard.
// Revision : 1.0
// ============================================================================
module lfsr_core #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(5),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(7'b0101110)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             enable,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    output logic      [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    assign w_fb  = ^(r_state & TAPS);
    assign state = r_state;

    // A zero seed or a zero state would lock the register; both fall back to SEED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (load_value == '0) ? SEED : load_value;
        end else if (enable) begin
            r_state <= (r_state == '0) ? SEED : {r_state[WIDTH-2:0], w_fb};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_draw_arbiter
// Purpose  : Round-robin shares one LFSR; draws with rejection and clamp.
// Revision : 1.0
// ============================================================================
module lfsr_draw_arbiter
    import lfsr_draw_pkg::*;
#(
    parameter int               WIDTH          = 7,
    parameter int               NUM_REQ        = 2,
    parameter logic [WIDTH-1:0] SEED           = WIDTH'(5),
    parameter logic [WIDTH-1:0] TAPS           = WIDTH'(7'b0101110),
    parameter int               STEPS_PER_DRAW = 7,
    parameter int               MAX_TRIES      = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    lfsr_draw_arbiter_if.slave bus
);

    localparam int c_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_STEP_W = $clog2(STEPS_PER_DRAW + 1);
    localparam int c_TRY_W  = $clog2(MAX_TRIES + 1);

    state_t              r_state, w_next;
    logic [c_IDX_W-1:0]  r_idx, r_rr_ptr, w_pick, w_idx_inc;
    logic [WIDTH-1:0]    r_bound, r_data, w_lfsr;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [c_TRY_W-1:0]  r_tries;
    logic                r_timed_out;
    logic [WIDTH-1:0]    w_bounds [NUM_REQ];
    logic                w_start, w_abort, w_hit, w_last_try, w_step_done;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bound
            assign w_bounds[gi] = bus.bound[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_pick      = c_IDX_W'(next_rr(int'(r_rr_ptr), c_MAX_REQ'(bus.req), NUM_REQ));
    assign w_idx_inc   = (r_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_start     = (r_state == IDLE) && !bus.reseed && (|bus.req);
    assign w_abort     = ((r_state == STEP) || (r_state == CHECK)) && !bus.req[r_idx];
    assign w_step_done = (r_step_cnt == c_STEP_W'(STEPS_PER_DRAW - 1));
    assign w_hit       = (w_lfsr <= r_bound);
    assign w_last_try  = (r_tries == c_TRY_W'(MAX_TRIES - 1));

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .enable     (r_state == STEP),
        .load       ((r_state == IDLE) && bus.reseed),
        .load_value (bus.seed_in),
        .state      (w_lfsr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_start) w_next = STEP;
            STEP:  if (w_abort) w_next = IDLE;
                   else if (w_step_done) w_next = CHECK;
            CHECK: if (w_abort) w_next = IDLE;
                   else if (w_hit || w_last_try) w_next = DONE;
                   else w_next = STEP;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.grant     = (r_state != IDLE) ? (NUM_REQ'(1) << r_idx) : '0;
        bus.valid     = (r_state == DONE);
        bus.busy      = (r_state != IDLE);
        bus.data      = r_data;
        bus.timed_out = r_timed_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_rr_ptr    <= '0;
            r_bound     <= '0;
            r_step_cnt  <= '0;
            r_tries     <= '0;
            r_data      <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx      <= w_pick;
                r_bound    <= w_bounds[w_pick];
                r_step_cnt <= '0;
                r_tries    <= '0;
            end
            if (r_state == STEP) r_step_cnt <= r_step_cnt + 1'b1;
            if ((r_state == CHECK) && !w_abort) begin
                if (w_hit) begin
                    r_data      <= w_lfsr;
                    r_timed_out <= 1'b0;
                end else if (w_last_try) begin
                    r_data      <= r_bound;
                    r_timed_out <= 1'b1;
                end else begin
                    r_tries    <= r_tries + 1'b1;
                    r_step_cnt <= '0;
                end
            end
            // Completion and abort both hand priority to the next requester.
            if ((r_state == DONE) || w_abort) r_rr_ptr <= w_idx_inc;
        end
    end

endmodule
`default_nettype wire

// File: doc/lfsr_draw_arbiter.md
Name: lfsr_draw_arbiter

Overview:
Shares one Fibonacci LFSR between NUM_REQ requesters, for example the x- and y-coordinate generators of the VGA pixel plotter. Each requester asks for a pseudo-random value in the range [0, bound]. The block grants the requesters round-robin, advances the LFSR several shifts per draw, and rejects out-of-range draws with retry. It returns the accepted value with a one-cycle valid pulse and clamps after MAX_TRIES failed draws.

Parameters:
WIDTH, 7, LFSR/data width in bits
NUM_REQ, 2, number of requesters
SEED, 5, reset and fallback LFSR state; must be nonzero
TAPS, 7'b0101110, feedback mask; feedback = XOR of state bits set in TAPS (bits 1,2,3,5)
STEPS_PER_DRAW, 7, LFSR shifts per draw (decorrelation)
MAX_TRIES, 16, draws before the clamp fallback

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request, level-held until valid
bound  input  NUM_REQ*WIDTH  per-requester inclusive upper bound; slice i belongs to req[i]
reseed  input  1  load seed_in into LFSR (honoured only in IDLE)
seed_in  input  WIDTH  reseed value
grant  output  NUM_REQ  one-hot owner of the current draw, 0 when idle
valid  output  1  one-cycle pulse, data valid for the granted requester
data  output  WIDTH  accepted value
timed_out  output  1  qualifies valid: result is the clamp fallback
busy  output  1  state != IDLE

Behaviour:
- Reset state: IDLE, lfsr=SEED, grant=0, valid=0, data=0, timed_out=0, busy=0, rr_ptr=0, step_cnt=0, tries=0.
- LFSR shift: state <= {state[WIDTH-2:0], fb}. If the state is ever all-zero, the next enabled cycle loads SEED (lock-up guard).
- FSM states: IDLE, STEP, CHECK, DONE.
- IDLE:
  - reseed=1 loads seed_in, or SEED if seed_in==0. Reseed has priority; a coincident req is serviced next cycle.
  - Otherwise, if any req is set, pick the first set req starting from rr_ptr, wrapping. Latch idx and bound[idx]. Set grant[idx]=1, step_cnt=0, tries=0, then go to STEP.
- STEP: LFSR enabled and step_cnt increments each cycle. After STEPS_PER_DRAW cycles, go to CHECK.
- CHECK: LFSR holds.
  - If lfsr <= latched bound (unsigned): data=lfsr, timed_out=0, go to DONE.
  - Else if tries+1 == MAX_TRIES: data=bound, timed_out=1, go to DONE.
  - Else tries++, step_cnt=0, go to STEP.
- DONE: valid=1 for exactly one cycle with grant still asserted. Then grant=0, rr_ptr=(idx+1) mod NUM_REQ, go to IDLE.
- data and timed_out hold their values until the next CHECK completion.
- Latency, measured from the IDLE cycle that samples req:
  - valid is high at cycle k*(STEPS_PER_DRAW+1)+1, where k is the number of draws (1..MAX_TRIES).
  - Best case is STEPS_PER_DRAW+2 = 9 cycles.
  - Worst case is MAX_TRIES*(STEPS_PER_DRAW+1)+1 = 129 cycles.
- Abort: if req[idx] drops during STEP or CHECK, go to IDLE next cycle with no valid pulse. Set grant=0 and advance rr_ptr past idx. The LFSR keeps its advanced state.
- Other req edges and a reseed received while busy are ignored.
- Bound changes after latching are ignored until the next grant.
- Fairness: a requester that holds req high after valid cannot win the next arbitration while another req is pending.
- Reset asserted mid-operation returns everything to the reset state immediately. No valid pulse is produced.

Decomposition:
- Package lfsr_draw_pkg: the state enum (IDLE, STEP, CHECK, DONE) and a function next_rr(ptr, req) returning the first set index at or after ptr.
- Sub-module lfsr_core (params WIDTH, SEED, TAPS; ports clk, reset, enable, load, load_value, state).
  - lfsr_core carries the shift, feedback and zero lock-up guard.
  - The arbiter owns the FSM, counters and round-robin pointer.

Test Plan:
- Reset, then req=2'b01 with bound0=127: grant=01 from cycle 1, valid at cycle 9, data = LFSR state after 7 shifts from 5, timed_out=0, busy falls the cycle after valid.
- req=2'b11 held, both bounds 127: grants alternate 01,10,01,10. Each valid is 9 cycles after its IDLE sample, and there is one IDLE cycle between transactions.
- req0 with bound0=0: the LFSR is never zero, so valid arrives at cycle 129 with data=0 and timed_out=1. A self-checking model counts exactly 16 CHECK visits.
- reseed=1 with seed_in=0 in IDLE: LFSR=5. With seed_in=7'h2A, a following draw matches the model seeded with 0x2A. Reseed pulsed during STEP has no effect on the state sequence.
- Drop req0 at cycle 4 of STEP: no valid, grant=0 next cycle, and a pending req1 is granted next.
- Assert reset at cycle 5 of a draw: all outputs zero and lfsr=SEED in the same cycle (asynchronous). A new req after reset is serviced normally.
